pc_gen: RTL

Program-counter generator for the fetch stage of the pipelined RV32 core. It holds the fetch PC and drives the instruction-cache request. It advances the PC on each accepted response and holds it while decode stalls. Branch and jump redirects are applied immediately or deferred until the outstanding I-cache transaction completes. It sits between the execute-stage redirect logic, the I-cache port and the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/pc_redirect_latch.sv | 31 +++
 rtl/pc_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, default reset vector
// and small alignment helper used by the PC generator.
package fetch_pkg;

  // Fetch FSM states of the PC generator.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    SQUASH = 2'd2,
    HOLD   = 2'd3
  } pc_gen_state_e;

  // Default first fetch address after reset (fetched directly).
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0060;

  // Default PC width and sequential increment.
  localparam int unsigned PC_WIDTH_DEFAULT = 32;
  localparam int unsigned PC_INC_DEFAULT   = 4;

  // True when the two low address bits describe a word-aligned target.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Pending redirect-target register. Holds the newest redirect target while an
// I-cache request is being squashed. Clear has priority over load.
module pc_redirect_latch #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] target_r;

  // Capture the newest redirect target; reset and clear empty the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      target_r <= {WIDTH{1'b0}};
    end else if (load) begin
      target_r <= d;
    end else begin
      target_r <= target_r;
    end
  end

  assign q = target_r;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage. Holds the fetch PC, drives
// the I-cache read request, advances on accepted responses, holds while
// decode stalls and applies redirects immediately or after the outstanding
// I-cache transaction completes.
// Optional feature: define PC_MISALIGN_CHECK_EN to reject redirects whose
// target is not word aligned and pulse misalign for one cycle instead.
module pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH     = PC_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEFAULT),
  parameter int unsigned      INC       = PC_INC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             imem_resp,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_addr,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  pc_gen_state_e    state_r;
  pc_gen_state_e    state_nxt_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_nxt_s;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] pending_s;
  logic             pend_load_s;
  logic             pend_clear_s;
  logic             imem_read_r;
  logic             misalign_r;
  logic             redirect_ok_s;
  logic             misalign_hit_s;

  // Sequential address; the adder wraps modulo 2^WIDTH.
  assign pc_inc_s = pc_r + INC_W;

`ifdef PC_MISALIGN_CHECK_EN
  // Accept only word-aligned redirects; flag the rejected ones.
  always_comb begin
    redirect_ok_s  = 1'b0;
    misalign_hit_s = 1'b0;
    if (redirect) begin
      if (is_word_aligned(redirect_pc[1:0])) begin
        redirect_ok_s  = 1'b1;
        misalign_hit_s = 1'b0;
      end else begin
        redirect_ok_s  = 1'b0;
        misalign_hit_s = 1'b1;
      end
    end else begin
      redirect_ok_s  = 1'b0;
      misalign_hit_s = 1'b0;
    end
  end
`else
  assign redirect_ok_s  = redirect;
  assign misalign_hit_s = 1'b0;
`endif

  // Next-state, next-PC and pending-target control of the fetch FSM.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    pend_load_s  = 1'b0;
    pend_clear_s = 1'b0;
    case (state_r)
      BOOT: begin
        state_nxt_s = FETCH;
        if (redirect_ok_s) begin
          pc_nxt_s = redirect_pc;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      FETCH: begin
        if (redirect_ok_s && imem_resp) begin
          // Response dropped, restart at the target right away.
          state_nxt_s = FETCH;
          pc_nxt_s    = redirect_pc;
        end else if (redirect_ok_s) begin
          // Keep the I-cache address stable until the response arrives.
          state_nxt_s = SQUASH;
          pend_load_s = 1'b1;
        end else if (imem_resp && !stall) begin
          state_nxt_s = FETCH;
          pc_nxt_s    = pc_inc_s;
        end else if (imem_resp) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      SQUASH: begin
        // Newest redirect wins over an earlier pending target.
        pend_load_s = redirect_ok_s;
        if (imem_resp) begin
          state_nxt_s  = FETCH;
          pend_clear_s = 1'b1;
          if (redirect_ok_s) begin
            pc_nxt_s = redirect_pc;
          end else begin
            pc_nxt_s = pending_s;
          end
        end else begin
          state_nxt_s = SQUASH;
        end
      end
      HOLD: begin
        if (redirect_ok_s) begin
          state_nxt_s = FETCH;
          pc_nxt_s    = redirect_pc;
        end else if (!stall) begin
          state_nxt_s = FETCH;
          pc_nxt_s    = pc_inc_s;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = BOOT;
        pc_nxt_s    = RESET_VEC;
      end
    endcase
  end

  // State, PC and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= BOOT;
      pc_r        <= RESET_VEC;
      imem_read_r <= 1'b0;
      misalign_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      imem_read_r <= (state_nxt_s == FETCH) || (state_nxt_s == SQUASH);
      misalign_r  <= misalign_hit_s;
    end
  end

  pc_redirect_latch #(
    .WIDTH (WIDTH)
  ) u_pending (
    .clk   (clk),
    .rst   (rst),
    .clear (pend_clear_s),
    .load  (pend_load_s),
    .d     (redirect_pc),
    .q     (pending_s)
  );

  // A live response (or a held one) is passed on unless redirected away.
  assign if_valid  = (((state_r == FETCH) && imem_resp) || (state_r == HOLD)) && !redirect_ok_s;
  assign imem_read = imem_read_r;
  assign imem_addr = pc_r;
  assign if_pc     = pc_r;
  assign misalign  = misalign_r;

endmodule
